// File: rtl/bheap_pkg.sv
// Shared definitions for the binary-heap scan sequencer.
//   - state_e      : sequencer states (IDLE, LOAD, GO, WAIT, UNLOAD)
//   - *_DEF        : default key width, chain depth and pass-count width
//   - cnt_width()  : bits needed to hold the values 0..depth
package bheap_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DEPTH_DEF  = 15;
    localparam int CWIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        GO     = 3'd2,
        WAIT   = 3'd3,
        UNLOAD = 3'd4
    } state_e;

    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bheap_down_counter.sv
// Loadable down counter used for both the word and the pass count.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clr_i          : synchronous clear (highest priority)
//   load_i         : load load_val_i (beats decrement)
//   dec_i          : decrement by one; saturates at zero, never wraps
//   count_o        : current count
//   zero_o         : count is zero
module bheap_down_counter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         dec_i,
    output logic [N-1:0] count_o,
    output logic         zero_o
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/bheap_scan_seq.sv
// Load -> run -> unload sequencer for a scan-mode binary-heap array.
// Shifts DEPTH keys into the heap scan chain, issues the programmed number
// of Go/Done passes, then shifts DEPTH node values back out as a stream.
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   start_i, passes_i, abort_i  : command strobe, pass count, abort
//   in_valid_i/in_ready_o/in_data_i     : input key stream
//   scan_enable_o/scan_out_o/scan_in_i  : heap scan chain (head out, tail in)
//   go_o, done_i                : pass request pulse / pass complete pulse
//   out_valid_o/out_ready_i/out_data_o  : output key stream
//   busy_o, finish_o            : not idle / unload completed pulse
//   state_o                     : current sequencer state (debug)
// Handshake: a word moves on a cycle where valid && ready are both high;
// valid never depends on ready, and out_data_o is combinational from the
// chain tail, so the sink takes it in the handshake cycle itself.
module bheap_scan_seq
    import bheap_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CWIDTH = CWIDTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CWIDTH-1:0] passes_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  in_data_i,
    output logic              scan_enable_o,
    output logic [WIDTH-1:0]  scan_out_o,
    input  logic [WIDTH-1:0]  scan_in_i,
    output logic              go_o,
    input  logic              done_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  out_data_o,
    output logic              busy_o,
    output logic              finish_o,
    output state_e            state_o
);

    localparam int WCW = cnt_width(DEPTH);

    state_e            state_q;
    logic              finish_q;

    logic [WCW-1:0]    word_cnt;
    logic              word_zero;
    logic              word_load;
    logic              word_dec;
    logic [CWIDTH-1:0] pass_cnt;
    logic              pass_zero;
    logic              pass_load;
    logic              pass_dec;

    logic              in_hs;
    logic              out_hs;
    logic              last_word;
    logic              last_pass;

    bheap_down_counter #(.N(WCW)) u_word_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (abort_i),
        .load_i     (word_load),
        .load_val_i (WCW'(DEPTH)),
        .dec_i      (word_dec),
        .count_o    (word_cnt),
        .zero_o     (word_zero)
    );

    bheap_down_counter #(.N(CWIDTH)) u_pass_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (abort_i),
        .load_i     (pass_load),
        .load_val_i (passes_i),
        .dec_i      (pass_dec),
        .count_o    (pass_cnt),
        .zero_o     (pass_zero)
    );

    always_comb begin
        in_hs     = (state_q == LOAD) && in_valid_i;
        out_hs    = (state_q == UNLOAD) && out_ready_i;
        // The count is checked before it moves, so "1" means this is the last word/pass.
        last_word = (word_cnt == WCW'(1));
        last_pass = (pass_cnt == CWIDTH'(1));

        word_load = 1'b0;
        word_dec  = 1'b0;
        pass_load = 1'b0;
        pass_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                word_load = start_i;
                pass_load = start_i;
            end
            LOAD: begin
                // Reload on the last key so UNLOAD starts with a full word count.
                word_load = in_hs && last_word;
                word_dec  = in_hs && !last_word && !word_zero;
            end
            WAIT: begin
                pass_dec = done_i;
            end
            UNLOAD: begin
                word_dec = out_hs && !word_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            finish_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) state_q <= LOAD;
                    end
                    LOAD: begin
                        if (in_hs && last_word) state_q <= pass_zero ? UNLOAD : GO;
                    end
                    GO: begin
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        if (done_i) state_q <= last_pass ? UNLOAD : GO;
                    end
                    UNLOAD: begin
                        if (out_hs && last_word) begin
                            state_q  <= IDLE;
                            finish_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        in_ready_o    = (state_q == LOAD);
        out_valid_o   = (state_q == UNLOAD);
        go_o          = (state_q == GO);
        busy_o        = (state_q != IDLE);
        finish_o      = finish_q;
        state_o       = state_q;
        scan_enable_o = in_hs || out_hs;
        // Zero fill on unload and outside LOAD/UNLOAD.
        scan_out_o    = in_hs ? in_data_i : '0;
        out_data_o    = out_valid_o ? scan_in_i : '0;
    end

endmodule

// File: tb/tb_bheap_scan_seq.sv
module tb_bheap_scan_seq;
  import bheap_pkg::*;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int CW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT signals
  logic          start;
  logic [CW-1:0] passes;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          scan_en;
  logic [W-1:0]  scan_out;
  logic [W-1:0]  scan_in;
  logic          go;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          finish;
  state_e        state;

  bheap_scan_seq #(.WIDTH(W), .DEPTH(D), .CWIDTH(CW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .passes_i      (passes),
    .abort_i       (abort),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .scan_enable_o (scan_en),
    .scan_out_o    (scan_out),
    .scan_in_i     (scan_in),
    .go_o          (go),
    .done_i        (done),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .busy_o        (busy),
    .finish_o      (finish),
    .state_o       (state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] key_q[$];
  int hs_cyc[$];
  bit rdy_pat[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // heap model: DEPTH-deep shift chain; each pass adds 1 to every node
  logic [W-1:0] chain[D];
  logic heap_done = 1'b0;
  logic spur_done = 1'b0;
  int   done_dly  = 3;
  bit   rnd_dly   = 1'b0;
  bit   rnd_rdy   = 1'b0;
  int   hcnt      = 0;
  int   hd;

  assign done    = heap_done | spur_done;
  assign scan_in = chain[D-1];

  always @(posedge clk) begin
    heap_done <= 1'b0;
    if (scan_en) begin
      for (int i = D - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= scan_out;
    end
    if (go) begin
      hd = rnd_dly ? int'($urandom_range(1, 4)) : done_dly;
      if (hd <= 1) begin
        heap_done <= 1'b1;
        for (int i = 0; i < D; i++) chain[i] <= chain[i] + 8'd1;
      end else begin
        hcnt <= hd - 1;
      end
    end else if (hcnt > 0) begin
      hcnt <= hcnt - 1;
      if (hcnt == 1) begin
        heap_done <= 1'b1;
        for (int i = 0; i < D; i++) chain[i] <= chain[i] + 8'd1;
      end
    end
  end

  // output sink ready, driven just after the rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
      else if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
    end
  end

  // monitor: samples one time unit after the falling edge
  int cyc = 0;
  int go_cnt = 0;
  int fin_cnt = 0;
  int last_out = -10;
  bit p_in_hs, p_done, p_go, p_ov, p_ordy;
  bit m_in_hs, m_out_hs;
  logic [W-1:0] p_data;

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      p_in_hs = 0; p_done = 0; p_go = 0; p_ov = 0; p_ordy = 0; p_data = '0;
    end else begin
      m_in_hs  = in_valid && in_ready;
      m_out_hs = out_valid && out_ready;
      check("scan_enable", 32'(scan_en), 32'(m_in_hs || m_out_hs));
      check("scan_out", 32'(scan_out), m_in_hs ? 32'(in_data) : 32'd0);
      check("out_data", 32'(out_data), out_valid ? 32'(scan_in) : 32'd0);
      if (out_valid && p_ov && !p_ordy) check("out_hold", 32'(out_data), 32'(p_data));
      if (m_out_hs) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        else check("out_key", 32'(out_data), 32'(exp_q.pop_front()));
        last_out = cyc;
        hs_cyc.push_back(cyc);
      end
      if (go) begin
        go_cnt++;
        check("go_cause", 32'(p_in_hs || p_done), 32'd1);
        check("go_gap", 32'(p_go), 32'd0);
      end
      if (out_valid && !p_ov) check("ov_cause", 32'(p_in_hs || p_done), 32'd1);
      if (finish) begin
        fin_cnt++;
        check("finish_time", 32'(cyc - last_out), 32'd1);
        check("finish_busy", 32'(busy), 32'd0);
      end
      p_in_hs = m_in_hs; p_done = done; p_go = go;
      p_ov = out_valid; p_ordy = out_ready; p_data = out_data;
    end
  end

  // driver tasks (called at a falling edge)
  task automatic do_start(input logic [CW-1:0] np);
    start = 1'b1;
    passes = np;
    @(negedge clk);
    start = 1'b0;
    passes = CW'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    check("in_ready_after_start", 32'(in_ready), 32'd1);
  endtask

  task automatic feed(input logic [W-1:0] k, input bit gaps);
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = k;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = W'($urandom);
  endtask

  task automatic wait_finish(input int fin0);
    int n;
    n = 0;
    while (fin_cnt == fin0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("finish_seen", 32'(fin_cnt - fin0), 32'd1);
  endtask

  task automatic run(input logic [CW-1:0] np, input bit gaps, input bit spur, input bit mid_start);
    int go0, fin0, n;
    logic [W-1:0] k;
    go0 = go_cnt;
    fin0 = fin_cnt;
    do_start(np);
    for (int i = 0; i < D; i++) begin
      if (key_q.size() > 0) k = key_q.pop_front();
      else k = W'($urandom);
      exp_q.push_back(W'(k + W'(np)));
      feed(k, gaps);
      if (spur && i == 0) begin
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
      end
    end
    if (mid_start) begin
      n = 0;
      while (!go && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      check("state_is_wait", 32'(state), 32'(WAIT));
      start = 1'b1;
      passes = 8'd7;
      @(negedge clk);
      start = 1'b0;
    end
    wait_finish(fin0);
    check("go_count", 32'(go_cnt - go0), 32'(np));
    check("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // main sequence
  int fin_a;

  initial begin
    rst_n = 1'b0;
    start = 1'b0; passes = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // reset asserted mid-LOAD with a key presented
    do_start(8'd0);
    in_valid = 1'b1;
    in_data = 8'h33;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_scan_en", 32'(scan_en), 32'd0);
    check("rst_scan_out", 32'(scan_out), 32'd0);
    check("rst_go", 32'(go), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy_mid", 32'(busy), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_state", 32'(state), 32'(IDLE));

    // pass-through: keys 5, 9, 2 back to back
    key_q = '{8'd5, 8'd9, 8'd2};
    hs_cyc.delete();
    run(8'd0, 1'b0, 1'b0, 1'b0);
    check("pt_hs_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) check("pt_consecutive", 32'(hs_cyc[2] - hs_cyc[0]), 32'd2);

    // pass counting with a spurious Done during LOAD
    done_dly = 3;
    run(8'd2, 1'b0, 1'b1, 1'b0);

    // output backpressure
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run(8'd1, 1'b0, 1'b0, 1'b0);
    check("bp_pattern_used", 32'(rdy_pat.size()), 32'd0);

    // abort after one key, then a fresh full run
    fin_a = fin_cnt;
    do_start(8'd1);
    feed(8'hAA, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state), 32'(IDLE));
    repeat (3) @(negedge clk);
    check("abort_no_finish", 32'(fin_cnt - fin_a), 32'd0);
    run(8'd1, 1'b0, 1'b0, 1'b0);
    check("abort_one_finish", 32'(fin_cnt - fin_a), 32'd1);

    // Start while in WAIT is ignored
    run(8'd3, 1'b0, 1'b0, 1'b1);

    // randomized runs
    rnd_rdy = 1'b1;
    rnd_dly = 1'b1;
    repeat (12) run(CW'($urandom_range(0, 4)), 1'b1, 1'b0, 1'b0);
    rnd_rdy = 1'b0;
    repeat (4) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
